// File: rtl/timer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_sched_pkg
// Description : Shared constants and types for the compare-channel scheduler:
//               slave register addresses, CTRL bit positions, channel limit
//               and the per-channel state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_sched_pkg;

  localparam int MAX_CH = 4;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_PEND     = 4'd1;
  localparam logic [3:0] ADDR_MASK     = 4'd2;
  localparam logic [3:0] ADDR_ARMED    = 4'd3;
  localparam int         ADDR_CMP_BASE = 4;

  localparam int CTRL_GEN_BIT    = 0;
  localparam int CTRL_DISARM_LSB = 16;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } ch_state_e;

  // CMP_n lives at 4+2n, PER_n directly above it.
  function automatic logic [3:0] cmp_addr(input int n);
    return 4'(ADDR_CMP_BASE + 2 * n);
  endfunction

  function automatic logic [3:0] per_addr(input int n);
    return 4'(ADDR_CMP_BASE + 2 * n + 1);
  endfunction

endpackage : timer_sched_pkg
`default_nettype wire

// File: rtl/timer_cmp_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_cmp_channel
// Description : One compare channel: IDLE/ARMED state machine, CMP and PER
//               registers and the periodic reload adder.
// Ports       : clock, resetn   - clock, synchronous active-low reset
//               gen_i           - global enable (no fire while low)
//               cmp_we_i        - load CMP from wdata_i and arm
//               per_we_i        - load PER from wdata_i
//               disarm_i        - return to IDLE
//               wdata_i         - bus write data
//               count_i         - free-running timer count
//               fire_o          - combinational fire strobe (pend set next edge)
//               armed_o/cmp_o/per_o - state readback
// Revision    : 1.0 - initial release
// ============================================================================
module timer_cmp_channel
  import timer_sched_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        gen_i,
  input  logic        cmp_we_i,
  input  logic        per_we_i,
  input  logic        disarm_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] count_i,
  output logic        fire_o,
  output logic        armed_o,
  output logic [31:0] cmp_o,
  output logic [31:0] per_o
);

  ch_state_e   state_q, state_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] per_q, per_d;
  logic        match;

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    per_d   = per_q;

    match  = (state_q == CH_ARMED) && gen_i && (count_i == cmp_q);
    // A bus write to CMP in the match cycle takes precedence over the fire.
    fire_o = match && !cmp_we_i;

    if (per_we_i) begin
      per_d = wdata_i;
    end

    if (cmp_we_i) begin
      cmp_d   = wdata_i;
      state_d = CH_ARMED;
    end else begin
      if (fire_o) begin
        // Reload uses the PER value held at the fire; a PER write in the
        // same cycle takes effect on the following fire.
        if (per_q != 32'd0) begin
          cmp_d = cmp_q + per_q;
        end else begin
          state_d = CH_IDLE;
        end
      end
      if (disarm_i) begin
        state_d = CH_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= CH_IDLE;
      cmp_q   <= 32'd0;
      per_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      per_q   <= per_d;
    end
  end

  assign armed_o = (state_q == CH_ARMED);
  assign cmp_o   = cmp_q;
  assign per_o   = per_q;

endmodule : timer_cmp_channel
`default_nettype wire

// File: rtl/timer_cmp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : timer_cmp_scheduler
// Description : Multi-channel compare scheduler on a simple memory-mapped
//               slave. Holds bus decode, CTRL/PEND/MASK, read mux and the
//               interrupt priority encoder; channels are timer_cmp_channel.
// Ports       : clock, resetn   - clock, synchronous active-low reset
//               address/writedata/write/read/chipselect - slave bus in
//               readdata/waitrequest - slave bus out (zero wait states)
//               count_in        - free-running timer count
//               irq/irq_id      - level interrupt and lowest pending channel
// Revision    : 1.0 - initial release
// ============================================================================
module timer_cmp_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic [31:0] count_in,
  output logic        irq,
  output logic [1:0]  irq_id
);

  logic              gen_q, gen_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  logic              wr_en;
  logic              rd_en;
  logic [NUM_CH-1:0] fire_vec;
  logic [NUM_CH-1:0] armed_vec;
  logic [NUM_CH-1:0] w1c_vec;
  logic [NUM_CH-1:0] active_vec;
  logic [31:0]       ch_cmp [NUM_CH];
  logic [31:0]       ch_per [NUM_CH];

  assign wr_en       = write && chipselect;
  assign rd_en       = read && chipselect;
  assign waitrequest = 1'b0;

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      timer_cmp_channel u_ch (
        .clock    (clock),
        .resetn   (resetn),
        .gen_i    (gen_q),
        .cmp_we_i (wr_en && (address == cmp_addr(n))),
        .per_we_i (wr_en && (address == per_addr(n))),
        .disarm_i (wr_en && (address == ADDR_CTRL) && writedata[CTRL_DISARM_LSB + n]),
        .wdata_i  (writedata),
        .count_i  (count_in),
        .fire_o   (fire_vec[n]),
        .armed_o  (armed_vec[n]),
        .cmp_o    (ch_cmp[n]),
        .per_o    (ch_per[n])
      );
    end
  endgenerate

  // Control/status register updates. A fire sets PEND over a coincident
  // write-1-to-clear so no event is lost.
  always_comb begin
    gen_d   = gen_q;
    mask_d  = mask_q;
    w1c_vec = '0;
    if (wr_en && (address == ADDR_CTRL)) begin
      gen_d = writedata[CTRL_GEN_BIT];
    end
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[NUM_CH-1:0];
    end
    if (wr_en && (address == ADDR_PEND)) begin
      w1c_vec = writedata[NUM_CH-1:0];
    end
    pend_d = (pend_q & ~w1c_vec) | fire_vec;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      gen_q  <= 1'b0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      gen_q  <= gen_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Combinational read mux; disarm bits of CTRL are strobes and read 0.
  always_comb begin
    readdata = 32'd0;
    if (rd_en) begin
      case (address)
        ADDR_CTRL:  readdata[CTRL_GEN_BIT] = gen_q;
        ADDR_PEND:  readdata[NUM_CH-1:0]   = pend_q;
        ADDR_MASK:  readdata[NUM_CH-1:0]   = mask_q;
        ADDR_ARMED: readdata[NUM_CH-1:0]   = armed_vec;
        default: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (address == cmp_addr(n)) readdata = ch_cmp[n];
            if (address == per_addr(n)) readdata = ch_per[n];
          end
        end
      endcase
    end
  end

  // Interrupt outputs come from registered state only.
  assign active_vec = pend_q & mask_q;
  assign irq        = gen_q && (|active_vec);

  always_comb begin
    irq_id = 2'd0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (active_vec[n]) irq_id = 2'(n);
    end
  end

endmodule : timer_cmp_scheduler
`default_nettype wire

// File: tb/tb_timer_cmp_scheduler.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_timer_cmp_scheduler
// Description : Directed self-checking bench for timer_cmp_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_cmp_scheduler;

  logic        clock;
  logic        resetn;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] count_in;
  logic        irq;
  logic [1:0]  irq_id;

  int n_checks = 0;
  int n_errors = 0;

  timer_cmp_scheduler #(.NUM_CH(4)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .address     (address),
    .writedata   (writedata),
    .write       (write),
    .read        (read),
    .chipselect  (chipselect),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .count_in    (count_in),
    .irq         (irq),
    .irq_id      (irq_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    write      = 1'b1;
    chipselect = 1'b1;
    tick();
    write      = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address    = a;
    read       = 1'b1;
    chipselect = 1'b1;
    #0.1;
    check(tag, readdata, exp);
    read       = 1'b0;
    chipselect = 1'b0;
    #0.1;
  endtask

  initial begin
    int first_hit;
    resetn = 1'b0; address = '0; writedata = '0; write = 1'b0;
    read = 1'b0; chipselect = 1'b0; count_in = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset state
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_irq_id", {30'd0, irq_id}, 32'd0);
    check("rst_rdata_idle", readdata, 32'd0);
    check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
    rd_chk("rst_ctrl", 4'd0, 32'd0);
    rd_chk("rst_armed", 4'd3, 32'd0);
    rd_chk("rst_cmp3", 4'd10, 32'd0);

    // One-shot on channel 0
    bus_wr(4'd0, 32'h1);
    bus_wr(4'd2, 32'h1);
    bus_wr(4'd5, 32'h0);
    bus_wr(4'd4, 32'd100);
    first_hit = -1;
    for (int i = 0; i <= 200; i++) begin
      count_in = 32'(i);
      tick();
      address = 4'd1; read = 1'b1; chipselect = 1'b1;
      #0.1;
      if (readdata[0] && first_hit < 0) first_hit = i;
      read = 1'b0; chipselect = 1'b0;
    end
    check("oneshot_edge", 32'(first_hit), 32'd100);
    rd_chk("oneshot_pend", 4'd1, 32'h1);
    rd_chk("oneshot_armed", 4'd3, 32'h0);
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    check("oneshot_id", {30'd0, irq_id}, 32'd0);
    bus_wr(4'd1, 32'h1);
    check("oneshot_clr_irq", {31'd0, irq}, 32'd0);

    // Periodic wrap on channel 1
    count_in = 32'hFFFF_FFEF;
    bus_wr(4'd2, 32'h2);
    bus_wr(4'd7, 32'h20);
    bus_wr(4'd6, 32'hFFFF_FFF0);
    count_in = 32'hFFFF_FFF0;
    tick();
    rd_chk("wrap_pend", 4'd1, 32'h2);
    rd_chk("wrap_cmp", 4'd6, 32'h0000_0010);
    rd_chk("wrap_armed", 4'd3, 32'h2);
    count_in = 32'h5;
    bus_wr(4'd1, 32'h2);
    count_in = 32'h10;
    tick();
    count_in = 32'h11;
    rd_chk("wrap_pend2", 4'd1, 32'h2);
    rd_chk("wrap_cmp2", 4'd6, 32'h0000_0030);
    bus_wr(4'd1, 32'h2);
    bus_wr(4'd0, 32'h1 | (32'h1 << 17));
    rd_chk("disarm_armed", 4'd3, 32'h0);
    rd_chk("disarm_ctrl", 4'd0, 32'h1);

    // Unmapped address
    bus_wr(4'd15, 32'hDEAD_BEEF);
    rd_chk("unmapped", 4'd15, 32'h0);

    // Collisions on channel 2
    count_in = 32'd0;
    bus_wr(4'd9, 32'h0);
    bus_wr(4'd8, 32'd300);
    count_in = 32'd300;
    tick();
    count_in = 32'd0;
    rd_chk("col_first_pend", 4'd1, 32'h4);
    bus_wr(4'd8, 32'd300);
    count_in = 32'd300;
    bus_wr(4'd1, 32'h4);          // W1C in the match cycle
    count_in = 32'd0;
    rd_chk("col_w1c_pend", 4'd1, 32'h4);
    bus_wr(4'd1, 32'h4);
    rd_chk("col_cleared", 4'd1, 32'h0);
    bus_wr(4'd8, 32'd300);
    count_in = 32'd300;
    bus_wr(4'd8, 32'd500);        // CMP write in the match cycle
    count_in = 32'd0;
    rd_chk("col_wr_pend", 4'd1, 32'h0);
    rd_chk("col_wr_cmp", 4'd8, 32'd500);
    rd_chk("col_wr_armed", 4'd3, 32'h4);

    // Priority: channels 1 and 3 together
    bus_wr(4'd0, 32'h1 | (32'h1 << 18));
    bus_wr(4'd2, 32'hA);
    bus_wr(4'd7, 32'h0);
    bus_wr(4'd11, 32'h0);
    bus_wr(4'd6, 32'd700);
    bus_wr(4'd10, 32'd700);
    count_in = 32'd700;
    tick();
    count_in = 32'd0;
    rd_chk("prio_pend", 4'd1, 32'hA);
    check("prio_id13", {30'd0, irq_id}, 32'd1);
    check("prio_irq", {31'd0, irq}, 32'd1);
    bus_wr(4'd1, 32'h2);
    check("prio_id3", {30'd0, irq_id}, 32'd3);
    bus_wr(4'd1, 32'h8);
    check("prio_none_irq", {31'd0, irq}, 32'd0);
    check("prio_none_id", {30'd0, irq_id}, 32'd0);

    // Gating by GEN
    bus_wr(4'd2, 32'h1);
    bus_wr(4'd5, 32'h0);
    bus_wr(4'd4, 32'd900);
    bus_wr(4'd0, 32'h0);
    count_in = 32'd900;
    tick();
    count_in = 32'd0;
    rd_chk("gate_pend", 4'd1, 32'h0);
    rd_chk("gate_armed", 4'd3, 32'h1);
    bus_wr(4'd0, 32'h1);
    for (int c = 899; c <= 902; c++) begin
      count_in = 32'(c);
      tick();
    end
    count_in = 32'd0;
    rd_chk("gate_fire", 4'd1, 32'h1);
    rd_chk("gate_idle", 4'd3, 32'h0);
    bus_wr(4'd1, 32'h1);

    // Reset in a match cycle
    bus_wr(4'd5, 32'd5);
    bus_wr(4'd4, 32'd1000);
    count_in = 32'd1000;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    count_in = 32'd0;
    rd_chk("mrst_pend", 4'd1, 32'h0);
    rd_chk("mrst_cmp0", 4'd4, 32'h0);
    rd_chk("mrst_per0", 4'd5, 32'h0);
    rd_chk("mrst_mask", 4'd2, 32'h0);
    rd_chk("mrst_ctrl", 4'd0, 32'h0);
    rd_chk("mrst_armed", 4'd3, 32'h0);
    check("mrst_irq", {31'd0, irq}, 32'd0);
    bus_wr(4'd0, 32'h1);
    tick();                       // count 0 == CMP_0 but channel is idle
    count_in = 32'd1000;
    tick();
    count_in = 32'd0;
    rd_chk("mrst_nofire", 4'd1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_timer_cmp_scheduler
`default_nettype wire
